// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/ready/valid handshake.
// Optional leading-zero blanking (4'hF) when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int NI = (WIDTH + 2) / 3;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int OD = (DIGITS > NI) ? DIGITS : NI;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [4*NI-1:0]     acc;
  logic [4*NI-1:0]     acc_adj;
  logic [WIDTH-1:0]    sr;
  logic [CW-1:0]       cnt;
  logic                sign_lat;
  logic                neg;
  logic [WIDTH-1:0]    mag;
  logic [4*OD-1:0]     acc_pad;
  logic [4*DIGITS-1:0] bcd_raw;
  logic [4*DIGITS-1:0] bcd_out;
  logic                ovf;

  // The most-negative input negates to 2^(WIDTH-1), which still fits unsigned.
  assign neg   = SIGNED && bin[WIDTH-1];
  assign mag   = neg ? (~bin + WIDTH'(1)) : bin;
  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < NI; k++) begin
      if (acc[4*k +: 4] > 4'd4) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sr       <= '0;
      cnt      <= '0;
      sign_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            sr       <= mag;
            cnt      <= CW'(WIDTH);
            sign_lat <= neg;
          end
        end
        CONV: begin
          {acc, sr} <= {acc_adj, sr} << 1;
          cnt       <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_pad            = '0;
    acc_pad[4*NI-1:0]  = acc;
    bcd_raw            = acc_pad[4*DIGITS-1:0];
    ovf                = 1'b0;
    for (int k = DIGITS; k < OD; k++) ovf = ovf | (|acc_pad[4*k +: 4]);
  end

`ifdef BIN2BCD_BLANK_EN
  // Blank zeros above the most significant nonzero digit; digit 0 always shows.
  always_comb begin
    logic lead;
    lead    = 1'b1;
    bcd_out = bcd_raw;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && !ovf && (bcd_raw[4*k +: 4] == 4'd0)) bcd_out[4*k +: 4] = 4'hF;
      else                                             lead = 1'b0;
    end
  end
`else
  assign bcd_out = bcd_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      sign     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        sign     <= sign_lat;
        bcd      <= bcd_out;
        overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an unsigned 16b/5-digit DUT and a signed 16b/4-digit DUT run in lockstep.
// Expected results come from a decimal arithmetic model; a monitor pops them on every valid pulse.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        ready_u, valid_u, sign_u, ovf_u;
  logic [19:0] bcd_u;
  logic        ready_s, valid_s, sign_s, ovf_s;
  logic [15:0] bcd_s;

  int compared;
  int mismatched;
  logic [31:0] q_u[$];
  logic [31:0] q_s[$];
  logic [31:0] prev_u;
  logic [31:0] prev_s;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready_u), .valid(valid_u), .sign(sign_u), .bcd(bcd_u), .overflow(ovf_u)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready_s), .valid(valid_s), .sign(sign_s), .bcd(bcd_s), .overflow(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result word layout: bit 21 sign, bit 20 overflow, bits 19:0 digits.
  function automatic logic [31:0] model(input int value, input bit sgn, input int digits);
    int mag;
    int p;
    bit neg;
    bit ovf;
    logic [31:0] r;
    neg = sgn && (value >= 32768);
    mag = neg ? (65536 - value) : value;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    ovf = (mag >= p);
    r = '0;
    p = 1;
    for (int k = 0; k < digits; k++) begin
      logic [3:0] d;
      d = 4'((mag / p) % 10);
`ifdef BIN2BCD_BLANK_EN
      if (!ovf && (k > 0) && (p > mag)) d = 4'hF;
`endif
      r[4*k +: 4] = d;
      p = p * 10;
    end
    r[21] = neg;
    r[20] = ovf;
    return r;
  endfunction

  function automatic logic [31:0] pack_u();
    return {10'b0, sign_u, ovf_u, bcd_u};
  endfunction

  function automatic logic [31:0] pack_s();
    return {10'b0, sign_s, ovf_s, 4'b0, bcd_s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid_u) begin
      if (q_u.size() == 0) checkOutput("unexpected_valid_u", 32'd1, 32'd0);
      else                 checkOutput("result_u", pack_u(), q_u.pop_front());
    end
    if (!rst && valid_s) begin
      if (q_s.size() == 0) checkOutput("unexpected_valid_s", 32'd1, 32'd0);
      else                 checkOutput("result_s", pack_s(), q_s.pop_front());
    end
  end

  // Busy pokes land once mid-CONV and once in the DONE cycle; neither may be accepted.
  task automatic applyStimulus(input logic [15:0] value, input bit poke);
    int lat;
    int lowc;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
    exp_u = model(int'(value), 1'b0, 5);
    exp_s = model(int'(value), 1'b1, 4);
    @(negedge clk);
    start = 1'b1;
    bin   = value;
    q_u.push_back(exp_u);
    q_s.push_back(exp_s);
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    lowc = 0;
    while (!valid_u && lat < 40) begin
      if (!ready_u) lowc++;
      if (lat == 5) begin
        checkOutput("hold_u", pack_u(), prev_u);
        checkOutput("hold_s", pack_s(), prev_s);
      end
      if (poke && (lat == 3 || lat == 16)) begin
        start = 1'b1;
        bin   = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(lat), 32'd17);
    checkOutput("ready_low_cycles", 32'(lowc), 32'd17);
    prev_u = exp_u;
    prev_s = exp_s;
  endtask

  task automatic resetMidConversion();
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset_u_outputs", pack_u(), 32'd0);
    checkOutput("midreset_u_hs", {30'b0, ready_u, valid_u}, 32'd2);
    checkOutput("midreset_s_outputs", pack_s(), 32'd0);
    checkOutput("midreset_s_hs", {30'b0, ready_s, valid_s}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    prev_u = '0;
    prev_s = '0;
    repeat (25) @(negedge clk);
    checkOutput("idle_after_reset", {30'b0, ready_u, ready_s}, 32'd3);
  endtask

  initial begin
    logic [15:0] directed[10];
    compared   = 0;
    mismatched = 0;
    prev_u     = '0;
    prev_s     = '0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    directed = '{16'd12345, 16'hFFFF, 16'h8000, 16'd0, 16'd9999,
                 16'd42, 16'h7FFF, 16'd10000, 16'd1, 16'd65535};

    repeat (3) @(negedge clk);
    checkOutput("reset_u_outputs", pack_u(), 32'd0);
    checkOutput("reset_u_hs", {30'b0, ready_u, valid_u}, 32'd2);
    checkOutput("reset_s_outputs", pack_s(), 32'd0);
    checkOutput("reset_s_hs", {30'b0, ready_s, valid_s}, 32'd2);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) applyStimulus(directed[i], (i % 2) == 0);
    for (int i = 0; i < 50; i++) applyStimulus(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

    resetMidConversion();
    applyStimulus(16'd42, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 32'(q_u.size() + q_s.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter for the LCD board display path. It uses iterative double-dabble, one bit per clock, so area stays constant as WIDTH grows. A start/ready/valid handshake sits between the value source (for example, the adder result register) and the LCD character formatter. It adds a signed/unsigned mode, an overflow flag for an insufficient digit count, and registered, held outputs.

Parameters:
WIDTH, 32, bit width of the binary input (minimum 4).
DIGITS, 10, number of BCD digits presented on the bcd port (minimum 1).
SIGNED, 1, 1 = bin is two's complement; 0 = bin is unsigned and sign is always 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request a conversion; accepted only when ready=1.
bin  input  WIDTH  binary value; sampled on the edge where start&&ready.
ready  output  1  converter idle; can accept start.
valid  output  1  one-cycle pulse; the new result is present on sign/bcd/overflow.
sign  output  1  1 = result negative (SIGNED=1 and bin MSB set).
bcd  output  4*DIGITS  packed digits; digit k occupies bits [4k+3:4k], digit 0 is least significant.
overflow  output  1  magnitude exceeds 10^DIGITS-1; bcd then holds the low DIGITS digits.

Behaviour:
- Reset values: ready=1, valid=0, sign=0, bcd=0, overflow=0; FSM in IDLE; internal registers cleared.
- Internal digit count: NI = (WIDTH+2)/3, using integer division; this always covers 2^WIDTH. The working register holds NI*4 BCD bits plus a WIDTH-bit shift register.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch the magnitude and the sign.
    - Magnitude = -bin if SIGNED && bin[WIDTH-1]; otherwise bin.
    - The most-negative input gives 2^(WIDTH-1), which fits as an unsigned WIDTH-bit value.
  - Clear the BCD accumulator, load the counter with WIDTH, go to CONV, and drop ready on the same edge.
- CONV, one iteration per edge:
  - Add 3 to every accumulator digit greater than 4.
  - Then shift {accumulator, shift register} left by 1.
  - Decrement the counter. When the counter reaches 0 on this edge, go to DONE.
- DONE, one cycle:
  - Register outputs: bcd = accumulator digits [DIGITS-1:0], or zero-extended if DIGITS > NI.
  - overflow = OR of accumulator digits at index >= DIGITS; constant 0 when DIGITS >= NI.
  - sign = latched sign.
  - Magnitude 0 always yields sign=0, so there is no negative zero.
  - valid=1 for exactly this cycle, ready=1 in this cycle, then return to IDLE.
- Latency:
  - start sampled at edge E0 gives valid high between edges E(WIDTH+1) and E(WIDTH+2).
  - Throughput is one conversion per WIDTH+2 cycles.
  - start held high in DONE is not accepted; it is accepted on the next IDLE edge.
- Start while busy: start in CONV or DONE is ignored and not queued; bin changes during CONV have no effect.
- Output hold: sign/bcd/overflow hold their last values until the next DONE; they do not change at start.
- Reset mid-conversion: the conversion is abandoned immediately, all outputs and state go to their reset values, and no valid is produced.

Optional Feature:
BIN2BCD_BLANK_EN
- Defined:
  - Leading-zero blanking is applied when the DONE outputs are registered.
  - Every digit above the most significant nonzero digit is output as 4'hF (the blank code for the LCD formatter).
  - Digit 0 is never blanked, so value 0 shows as ...FFF0.
  - When overflow=1, no blanking is applied.
- Undefined: leading digits are output as 4'h0, as described in Behaviour.

Test Plan:
- WIDTH=16, DIGITS=5, SIGNED=0: start with bin=16'd12345 -> valid exactly 17 cycles after the start edge; bcd=20'h12345, sign=0, overflow=0; ready low for 17 cycles.
- WIDTH=16, DIGITS=5, SIGNED=1: bin=16'hFFFF -> sign=1, bcd=20'h00001. bin=16'h8000 -> sign=1, bcd=20'h32768. bin=0 -> sign=0, bcd=0.
- WIDTH=16, DIGITS=4, SIGNED=0: bin=16'd65535 -> overflow=1, bcd=16'h5535. bin=16'd9999 -> overflow=0, bcd=16'h9999.
- Start pulses with bin=1 while busy, during CONV and during DONE -> only one valid, for the original value; the result is not 1; next accepted start converts correctly.
- Assert rst 5 cycles into a conversion of 16'd4321 -> outputs all 0 and ready=1 immediately; no valid pulse; a subsequent start of 16'd42 gives bcd=20'h00042.
- With BIN2BCD_BLANK_EN, WIDTH=16, DIGITS=5, SIGNED=0: bin=16'd42 -> bcd=20'hFFF42. bin=0 -> bcd=20'hFFFF0.
